vp_mac_stream_driver: RTL and testbench
=======================================

Name: vp_mac_stream_driver

Overview:
- AXIS master-side driver for the variable-precision temporal MAC.
- Holds a small buffer of {activation, weight} byte pairs, written by a local write port.
- On a command it streams one complete MAC transaction: optional precision beat, dequant-scale beat, data beats, then a trailing flush beat.
- It then accepts the MAC's single result beat and presents it to the controller with a one-cycle done pulse.

Parameters:
AXIS_DW, 32, AXIS TDATA width (>=32)
DEPTH, 16, buffer entries (power of two, >=2)
ADDR_W, $clog2(DEPTH), buffer address width

Ports:
CLK  in  1  clock
RESET  in  1  synchronous active-high reset
BUF_WE  in  1  buffer write enable
BUF_WADDR  in  ADDR_W  buffer write address
BUF_WDATA  in  16  {activation[15:8], weight[7:0]}
CMD_VALID  in  1  command request
CMD_READY  out  1  high only in IDLE
CMD_SEND_PREC  in  1  1: emit precision beat
CMD_PRECISION  in  4  precision code 0..8
CMD_SCALE  in  32  dequant scale word
CMD_LEN  in  ADDR_W+1  data beats, 0..DEPTH
CMD_TID  in  8  TID for all beats
MO_AXIS_TVALID  out  1  stream to MAC
MO_AXIS_TDATA  out  AXIS_DW  beat payload
MO_AXIS_TUSER  out  1  1 only on precision beat
MO_AXIS_TLAST  out  1  see Behaviour
MO_AXIS_TID  out  8  latched CMD_TID
MO_AXIS_TREADY  in  1  MAC ready
SD_AXIS_TVALID  in  1  result from MAC
SD_AXIS_TDATA  in  AXIS_DW  result word
SD_AXIS_TLAST  in  1  result last
SD_AXIS_TID  in  8  result TID
SD_AXIS_TREADY  out  1  high only in WAIT_RES
RES_VALID  out  1  one-cycle done pulse
RES_DATA  out  AXIS_DW  captured result, held
RES_TID  out  8  captured TID, held
RES_LAST  out  1  captured TLAST, held
RES_ERR  out  1  captured TID != latched CMD_TID, held
BUSY  out  1  state != IDLE

Behaviour:
- Reset (synchronous, RESET=1 at a CLK edge):
  - state=IDLE, all outputs 0 except CMD_READY=1.
  - Buffer entries cleared to 0; beat index = 0.
  - Reset mid-transaction aborts it; TVALID is low from the next cycle.
- Command accept: a CMD_VALID&&CMD_READY handshake latches all CMD_* fields. CMD_LEN>DEPTH is clamped to DEPTH.
  - Next state is SEND_PREC if CMD_SEND_PREC=1, else SEND_SCALE.
- Buffer writes are honoured only in IDLE; BUF_WE while BUSY=1 is ignored.
- States (stream beats advance only on an MO handshake):
  - IDLE: wait for command.
  - SEND_PREC: TDATA={0,precision[3:0]}, TUSER=1, TLAST=0 -> SEND_SCALE.
  - SEND_SCALE: TDATA=scale (zero-extended), TUSER=0, TLAST=(LEN==0).
    - -> SEND_DATA if LEN>0, else SEND_FLUSH.
  - SEND_DATA: TDATA={0, buf[idx]}, TLAST=(idx==LEN-1). idx++ per handshake.
    - The handshake with idx==LEN-1 goes -> SEND_FLUSH.
  - SEND_FLUSH: TDATA=0, TUSER=0, TLAST=1. This beat is mandatory: the MAC consumes one extra beat after TLAST before computing.
    - -> WAIT_RES.
  - WAIT_RES: SD_AXIS_TREADY=1. On handshake, capture RES_DATA/RES_TID/RES_LAST and RES_ERR -> DONE.
  - DONE: RES_VALID=1 for exactly one cycle -> IDLE.
- MO_AXIS_TVALID=1 in all SEND_* states, including the cycle after command accept.
- TDATA/TUSER/TLAST/TID stay stable while TVALID=1 && TREADY=0.
- Zero-wait streaming: with TREADY held high, one beat per cycle, no bubbles between beats.
- Beat count per transaction = (SEND_PREC?1:0) + 1 + LEN + 1.
- Upper TDATA bits above the defined fields are always 0.
- SD_AXIS_TVALID outside WAIT_RES is ignored (TREADY=0).
- No timeout: a missing result leaves the block in WAIT_RES until reset.

Test Plan:
- Reset sequence -> CMD_READY=1, BUSY=0, MO_AXIS_TVALID=0, RES_*=0.
- Buffer {0x0302, 0x05FF}; command SEND_PREC=1, PRECISION=0, SCALE=0x00010000, LEN=2, TID=0x5A; TREADY always 1 -> 5 consecutive beats:
  - TDATA 0x0 (TUSER=1), 0x00010000, 0x0302, 0x05FF (TLAST=1), 0x0 (TLAST=1).
  - All beats carry TID=0x5A.
- Same command with SEND_PREC=0 and TREADY random ~50% -> 4 beats, identical payloads, each held stable while stalled, no beat dropped or duplicated.
- LEN=0 -> scale beat with TLAST=1, then flush beat, then WAIT_RES.
- Responder returns TDATA=0xDEADBEEF, TID=0x5A, TLAST=1 after 7 cycles -> RES_VALID pulses one cycle later for 1 cycle; RES_DATA=0xDEADBEEF, RES_ERR=0.
  - Repeat with TID=0x11 -> RES_ERR=1.
- Corner cases:
  - BUF_WE to idx 0 during SEND_DATA -> streamed data unchanged.
  - RESET asserted mid-SEND_DATA -> next cycle TVALID=0, CMD_READY=1; a new command then runs cleanly.

Source files
------------

// File: rtl/vp_mac_stream_driver_if.sv
// Stream bundle between the MAC driver and the variable-precision MAC:
// the operand stream towards the MAC and the result stream coming back.
interface vp_mac_stream_driver_if #(
  parameter int unsigned AXIS_DW = 32
);
  logic               MO_AXIS_TVALID;
  logic [AXIS_DW-1:0] MO_AXIS_TDATA;
  logic               MO_AXIS_TUSER;
  logic               MO_AXIS_TLAST;
  logic [7:0]         MO_AXIS_TID;
  logic               MO_AXIS_TREADY;

  logic               SD_AXIS_TVALID;
  logic [AXIS_DW-1:0] SD_AXIS_TDATA;
  logic               SD_AXIS_TLAST;
  logic [7:0]         SD_AXIS_TID;
  logic               SD_AXIS_TREADY;

  modport master (
    output MO_AXIS_TVALID, MO_AXIS_TDATA, MO_AXIS_TUSER, MO_AXIS_TLAST, MO_AXIS_TID,
    input  MO_AXIS_TREADY,
    input  SD_AXIS_TVALID, SD_AXIS_TDATA, SD_AXIS_TLAST, SD_AXIS_TID,
    output SD_AXIS_TREADY
  );

  modport slave (
    input  MO_AXIS_TVALID, MO_AXIS_TDATA, MO_AXIS_TUSER, MO_AXIS_TLAST, MO_AXIS_TID,
    output MO_AXIS_TREADY,
    output SD_AXIS_TVALID, SD_AXIS_TDATA, SD_AXIS_TLAST, SD_AXIS_TID,
    input  SD_AXIS_TREADY
  );
endinterface

// File: rtl/vp_mac_stream_driver.sv
// Streams one MAC transaction (precision, scale, data, flush) from a local
// operand buffer and captures the single result beat returned by the MAC.
module vp_mac_stream_driver #(
  parameter int unsigned AXIS_DW = 32,
  parameter int unsigned DEPTH   = 16,
  parameter int unsigned ADDR_W  = $clog2(DEPTH)
) (
  input  logic                CLK,
  input  logic                RESET,
  input  logic                BUF_WE,
  input  logic [ADDR_W-1:0]   BUF_WADDR,
  input  logic [15:0]         BUF_WDATA,
  input  logic                CMD_VALID,
  output logic                CMD_READY,
  input  logic                CMD_SEND_PREC,
  input  logic [3:0]          CMD_PRECISION,
  input  logic [31:0]         CMD_SCALE,
  input  logic [ADDR_W:0]     CMD_LEN,
  input  logic [7:0]          CMD_TID,
  vp_mac_stream_driver_if.master axis,
  output logic                RES_VALID,
  output logic [AXIS_DW-1:0]  RES_DATA,
  output logic [7:0]          RES_TID,
  output logic                RES_LAST,
  output logic                RES_ERR,
  output logic                BUSY
);
  localparam int unsigned LEN_W = ADDR_W + 1;

  typedef enum logic [2:0] {
    S_IDLE, S_SEND_PREC, S_SEND_SCALE, S_SEND_DATA, S_SEND_FLUSH, S_WAIT_RES, S_DONE
  } state_t;

  state_t              state_q, state_nxt;
  logic [ADDR_W-1:0]   idx_q, idx_nxt;
  logic [3:0]          prec_q, prec_nxt;
  logic [31:0]         scale_q, scale_nxt;
  logic [LEN_W-1:0]    len_q, len_nxt;
  logic [7:0]          tid_q, tid_nxt;
  logic [15:0]         mem_q [DEPTH];

  logic                tvalid_q, tvalid_nxt;
  logic [AXIS_DW-1:0]  tdata_q, tdata_nxt;
  logic                tuser_q, tuser_nxt;
  logic                tlast_q, tlast_nxt;
  logic                sd_tready_q;
  logic                cmd_ready_q, busy_q, res_valid_q;
  logic [AXIS_DW-1:0]  res_data_q;
  logic [7:0]          res_tid_q;
  logic                res_last_q, res_err_q;
  logic                mo_hs, sd_hs, last_data;

  // Operand buffer; only writable while no transaction is in flight
  always_ff @(posedge CLK) begin
    if (RESET) begin
      for (int i = 0; i < int'(DEPTH); i++) mem_q[i] <= '0;
    end else if (BUF_WE && (state_q == S_IDLE)) begin
      mem_q[BUF_WADDR] <= BUF_WDATA;
    end
  end

  // Next state plus the beat that will be presented in that state
  always_comb begin
    state_nxt  = state_q;
    idx_nxt    = idx_q;
    prec_nxt   = prec_q;
    scale_nxt  = scale_q;
    len_nxt    = len_q;
    tid_nxt    = tid_q;
    tvalid_nxt = 1'b0;
    tdata_nxt  = '0;
    tuser_nxt  = 1'b0;
    tlast_nxt  = 1'b0;
    mo_hs      = tvalid_q && axis.MO_AXIS_TREADY;
    sd_hs      = sd_tready_q && axis.SD_AXIS_TVALID;
    last_data  = ({1'b0, idx_q} == (len_q - LEN_W'(1)));

    case (state_q)
      S_IDLE: begin
        if (CMD_VALID) begin
          prec_nxt  = CMD_PRECISION;
          scale_nxt = CMD_SCALE;
          len_nxt   = (CMD_LEN > LEN_W'(DEPTH)) ? LEN_W'(DEPTH) : CMD_LEN;
          tid_nxt   = CMD_TID;
          idx_nxt   = '0;
          state_nxt = CMD_SEND_PREC ? S_SEND_PREC : S_SEND_SCALE;
        end
      end
      S_SEND_PREC:  if (mo_hs) state_nxt = S_SEND_SCALE;
      S_SEND_SCALE: begin
        if (mo_hs) begin
          idx_nxt   = '0;
          state_nxt = (len_q == '0) ? S_SEND_FLUSH : S_SEND_DATA;
        end
      end
      S_SEND_DATA: begin
        if (mo_hs) begin
          if (last_data) state_nxt = S_SEND_FLUSH;
          else           idx_nxt   = idx_q + ADDR_W'(1);
        end
      end
      S_SEND_FLUSH: if (mo_hs) state_nxt = S_WAIT_RES;
      S_WAIT_RES:   if (sd_hs) state_nxt = S_DONE;
      S_DONE:       state_nxt = S_IDLE;
      default:      state_nxt = S_IDLE;
    endcase

    case (state_nxt)
      S_SEND_PREC: begin
        tvalid_nxt = 1'b1;
        tdata_nxt  = AXIS_DW'(prec_nxt);
        tuser_nxt  = 1'b1;
      end
      S_SEND_SCALE: begin
        tvalid_nxt = 1'b1;
        tdata_nxt  = AXIS_DW'(scale_nxt);
        tlast_nxt  = (len_nxt == '0);
      end
      S_SEND_DATA: begin
        tvalid_nxt = 1'b1;
        tdata_nxt  = AXIS_DW'(mem_q[idx_nxt]);
        tlast_nxt  = ({1'b0, idx_nxt} == (len_nxt - LEN_W'(1)));
      end
      S_SEND_FLUSH: begin
        tvalid_nxt = 1'b1;
        tlast_nxt  = 1'b1;
      end
      default: ;
    endcase
  end

  always_ff @(posedge CLK) begin
    if (RESET) begin
      state_q     <= S_IDLE;
      idx_q       <= '0;
      prec_q      <= '0;
      scale_q     <= '0;
      len_q       <= '0;
      tid_q       <= '0;
      tvalid_q    <= 1'b0;
      tdata_q     <= '0;
      tuser_q     <= 1'b0;
      tlast_q     <= 1'b0;
      sd_tready_q <= 1'b0;
      cmd_ready_q <= 1'b1;
      busy_q      <= 1'b0;
      res_valid_q <= 1'b0;
      res_data_q  <= '0;
      res_tid_q   <= '0;
      res_last_q  <= 1'b0;
      res_err_q   <= 1'b0;
    end else begin
      state_q     <= state_nxt;
      idx_q       <= idx_nxt;
      prec_q      <= prec_nxt;
      scale_q     <= scale_nxt;
      len_q       <= len_nxt;
      tid_q       <= tid_nxt;
      tvalid_q    <= tvalid_nxt;
      tdata_q     <= tdata_nxt;
      tuser_q     <= tuser_nxt;
      tlast_q     <= tlast_nxt;
      sd_tready_q <= (state_nxt == S_WAIT_RES);
      cmd_ready_q <= (state_nxt == S_IDLE);
      busy_q      <= (state_nxt != S_IDLE);
      res_valid_q <= (state_nxt == S_DONE);
      if (sd_hs) begin
        res_data_q <= axis.SD_AXIS_TDATA;
        res_tid_q  <= axis.SD_AXIS_TID;
        res_last_q <= axis.SD_AXIS_TLAST;
        res_err_q  <= (axis.SD_AXIS_TID != tid_q);
      end
    end
  end

  assign axis.MO_AXIS_TVALID = tvalid_q;
  assign axis.MO_AXIS_TDATA  = tdata_q;
  assign axis.MO_AXIS_TUSER  = tuser_q;
  assign axis.MO_AXIS_TLAST  = tlast_q;
  assign axis.MO_AXIS_TID    = tid_q;
  assign axis.SD_AXIS_TREADY = sd_tready_q;
  assign CMD_READY = cmd_ready_q;
  assign BUSY      = busy_q;
  assign RES_VALID = res_valid_q;
  assign RES_DATA  = res_data_q;
  assign RES_TID   = res_tid_q;
  assign RES_LAST  = res_last_q;
  assign RES_ERR   = res_err_q;
endmodule

// File: tb/tb_vp_mac_stream_driver.sv
// Directed bench for vp_mac_stream_driver: beat sequences, stalls, result
// capture, buffer write lockout, mid-transaction reset and length clamp.
module tb_vp_mac_stream_driver;
  localparam int unsigned AXIS_DW = 32;
  localparam int unsigned ADDR_W  = 4;

  logic              CLK = 1'b0;
  logic              RESET;
  logic              BUF_WE;
  logic [ADDR_W-1:0] BUF_WADDR;
  logic [15:0]       BUF_WDATA;
  logic              CMD_VALID;
  logic              CMD_READY;
  logic              CMD_SEND_PREC;
  logic [3:0]        CMD_PRECISION;
  logic [31:0]       CMD_SCALE;
  logic [ADDR_W:0]   CMD_LEN;
  logic [7:0]        CMD_TID;
  logic              RES_VALID;
  logic [31:0]       RES_DATA;
  logic [7:0]        RES_TID;
  logic              RES_LAST;
  logic              RES_ERR;
  logic              BUSY;

  int n_checks = 0;
  int n_errors = 0;
  logic [63:0] got_q[$];
  logic [63:0] exp_q[$];

  always #5 CLK = ~CLK;

  vp_mac_stream_driver_if #(.AXIS_DW(AXIS_DW)) axis ();

  vp_mac_stream_driver #(.AXIS_DW(AXIS_DW), .DEPTH(16)) dut (
    .CLK(CLK), .RESET(RESET),
    .BUF_WE(BUF_WE), .BUF_WADDR(BUF_WADDR), .BUF_WDATA(BUF_WDATA),
    .CMD_VALID(CMD_VALID), .CMD_READY(CMD_READY), .CMD_SEND_PREC(CMD_SEND_PREC),
    .CMD_PRECISION(CMD_PRECISION), .CMD_SCALE(CMD_SCALE), .CMD_LEN(CMD_LEN), .CMD_TID(CMD_TID),
    .axis(axis),
    .RES_VALID(RES_VALID), .RES_DATA(RES_DATA), .RES_TID(RES_TID),
    .RES_LAST(RES_LAST), .RES_ERR(RES_ERR), .BUSY(BUSY)
  );

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge CLK);
    #1;
  endtask

  function automatic logic [63:0] beat(input logic [7:0] tid, input logic u, input logic l,
                                        input logic [31:0] d);
    return {22'd0, tid, u, l, d};
  endfunction

  function automatic logic [63:0] cur_beat();
    return beat(axis.MO_AXIS_TID, axis.MO_AXIS_TUSER, axis.MO_AXIS_TLAST, axis.MO_AXIS_TDATA);
  endfunction

  task automatic buf_write(input logic [ADDR_W-1:0] a, input logic [15:0] d);
    BUF_WE = 1'b1; BUF_WADDR = a; BUF_WDATA = d;
    step();
    BUF_WE = 1'b0;
  endtask

  task automatic send_cmd(input logic sp, input logic [3:0] prec, input logic [31:0] sc,
                          input logic [ADDR_W:0] len, input logic [7:0] tid);
    check("cmd_ready_idle", 64'(CMD_READY), 64'(1));
    CMD_VALID = 1'b1; CMD_SEND_PREC = sp; CMD_PRECISION = prec;
    CMD_SCALE = sc; CMD_LEN = len; CMD_TID = tid;
    step();
    CMD_VALID = 1'b0;
    check("tvalid_after_accept", 64'(axis.MO_AXIS_TVALID), 64'(1));
    check("busy_after_accept", 64'(BUSY), 64'(1));
    check("cmd_ready_busy", 64'(CMD_READY), 64'(0));
  endtask

  // Drain the MO stream until WAIT_RES, recording each accepted beat
  task automatic run_stream(input bit rand_ready, input bit poke);
    int          cyc     = 0;
    int          bubbles = 0;
    bit          stalled = 1'b0;
    logic [63:0] held    = '0;
    got_q.delete();
    while (axis.SD_AXIS_TREADY !== 1'b1 && cyc < 400) begin
      axis.MO_AXIS_TREADY = rand_ready ? 1'($urandom_range(0, 1)) : 1'b1;
      if (axis.MO_AXIS_TVALID) begin
        if (stalled) check("hold_stable", cur_beat(), held);
        if (axis.MO_AXIS_TREADY) got_q.push_back(cur_beat());
        stalled = !axis.MO_AXIS_TREADY;
        held    = cur_beat();
      end else begin
        bubbles++;
        stalled = 1'b0;
      end
      if (poke) begin
        BUF_WE = 1'b1; BUF_WADDR = '0; BUF_WDATA = 16'hAAAA;
      end
      step();
      cyc++;
    end
    BUF_WE = 1'b0;
    axis.MO_AXIS_TREADY = 1'b0;
    check("reached_wait_res", 64'(axis.SD_AXIS_TREADY), 64'(1));
    check("tvalid_in_wait", 64'(axis.MO_AXIS_TVALID), 64'(0));
    if (!rand_ready) check("no_bubbles", 64'(bubbles), 64'(0));
  endtask

  task automatic compare_beats();
    check("beat_count", 64'(got_q.size()), 64'(exp_q.size()));
    foreach (exp_q[i])
      check($sformatf("beat%0d", i), (i < got_q.size()) ? got_q[i] : '1, exp_q[i]);
  endtask

  task automatic respond(input int dly, input logic [31:0] d, input logic [7:0] tid,
                         input logic last, input logic exp_err);
    repeat (dly) step();
    check("still_waiting", 64'(axis.SD_AXIS_TREADY), 64'(1));
    axis.SD_AXIS_TVALID = 1'b1; axis.SD_AXIS_TDATA = d;
    axis.SD_AXIS_TID = tid; axis.SD_AXIS_TLAST = last;
    step();
    axis.SD_AXIS_TVALID = 1'b0;
    check("res_valid_pulse", 64'(RES_VALID), 64'(1));
    check("res_data", 64'(RES_DATA), 64'(d));
    check("res_tid", 64'(RES_TID), 64'(tid));
    check("res_last", 64'(RES_LAST), 64'(last));
    check("res_err", 64'(RES_ERR), 64'(exp_err));
    check("sd_tready_done", 64'(axis.SD_AXIS_TREADY), 64'(0));
    step();
    check("res_valid_drop", 64'(RES_VALID), 64'(0));
    check("cmd_ready_back", 64'(CMD_READY), 64'(1));
    check("res_data_held", 64'(RES_DATA), 64'(d));
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    RESET = 1'b1; BUF_WE = 1'b0; BUF_WADDR = '0; BUF_WDATA = '0;
    CMD_VALID = 1'b0; CMD_SEND_PREC = 1'b0; CMD_PRECISION = '0; CMD_SCALE = '0;
    CMD_LEN = '0; CMD_TID = '0;
    axis.MO_AXIS_TREADY = 1'b0; axis.SD_AXIS_TVALID = 1'b0; axis.SD_AXIS_TDATA = '0;
    axis.SD_AXIS_TLAST = 1'b0; axis.SD_AXIS_TID = '0;
    step(); step();
    check("rst_cmd_ready", 64'(CMD_READY), 64'(1));
    check("rst_busy", 64'(BUSY), 64'(0));
    check("rst_tvalid", 64'(axis.MO_AXIS_TVALID), 64'(0));
    check("rst_sd_tready", 64'(axis.SD_AXIS_TREADY), 64'(0));
    check("rst_res", 64'({RES_VALID, RES_DATA, RES_TID, RES_LAST, RES_ERR}), 64'(0));
    RESET = 1'b0;
    step();

    // Result beats outside WAIT_RES are not accepted
    axis.SD_AXIS_TVALID = 1'b1; axis.SD_AXIS_TDATA = 32'h1234_5678; axis.SD_AXIS_TID = 8'h5A;
    step();
    check("sd_ignored_ready", 64'(axis.SD_AXIS_TREADY), 64'(0));
    check("sd_ignored_data", 64'(RES_DATA), 64'(0));
    axis.SD_AXIS_TVALID = 1'b0;

    buf_write(4'd0, 16'h0302);
    buf_write(4'd1, 16'h05FF);

    // Precision beat, zero-wait streaming
    send_cmd(1'b1, 4'd0, 32'h0001_0000, 5'd2, 8'h5A);
    run_stream(1'b0, 1'b0);
    exp_q = '{beat(8'h5A, 1, 0, 32'h0), beat(8'h5A, 0, 0, 32'h0001_0000),
              beat(8'h5A, 0, 0, 32'h0302), beat(8'h5A, 0, 1, 32'h05FF),
              beat(8'h5A, 0, 1, 32'h0)};
    compare_beats();
    respond(7, 32'hDEAD_BEEF, 8'h5A, 1'b1, 1'b0);

    // No precision beat, random back-pressure, buffer pokes while busy
    send_cmd(1'b0, 4'd0, 32'h0001_0000, 5'd2, 8'h5A);
    run_stream(1'b1, 1'b1);
    exp_q = '{beat(8'h5A, 0, 0, 32'h0001_0000), beat(8'h5A, 0, 0, 32'h0302),
              beat(8'h5A, 0, 1, 32'h05FF), beat(8'h5A, 0, 1, 32'h0)};
    compare_beats();
    respond(7, 32'hDEAD_BEEF, 8'h11, 1'b1, 1'b1);

    // Zero-length: scale beat carries TLAST, then flush
    send_cmd(1'b1, 4'd8, 32'hCAFE_F00D, 5'd0, 8'h33);
    run_stream(1'b0, 1'b0);
    exp_q = '{beat(8'h33, 1, 0, 32'h8), beat(8'h33, 0, 1, 32'hCAFE_F00D),
              beat(8'h33, 0, 1, 32'h0)};
    compare_beats();
    respond(2, 32'h0BAD_F00D, 8'h33, 1'b0, 1'b0);

    // Reset while stalled in SEND_DATA
    send_cmd(1'b0, 4'd0, 32'h0001_0000, 5'd2, 8'h77);
    axis.MO_AXIS_TREADY = 1'b1;
    step();
    axis.MO_AXIS_TREADY = 1'b0;
    step();
    check("mid_data_beat", cur_beat(), beat(8'h77, 0, 0, 32'h0302));
    RESET = 1'b1;
    step();
    RESET = 1'b0;
    check("abort_tvalid", 64'(axis.MO_AXIS_TVALID), 64'(0));
    check("abort_cmd_ready", 64'(CMD_READY), 64'(1));
    check("abort_busy", 64'(BUSY), 64'(0));
    check("abort_res_data", 64'(RES_DATA), 64'(0));
    step();

    // Clamped length over a freshly cleared buffer
    buf_write(4'd15, 16'h1234);
    send_cmd(1'b0, 4'd0, 32'h0000_0042, 5'd20, 8'h21);
    run_stream(1'b0, 1'b0);
    exp_q.delete();
    exp_q.push_back(beat(8'h21, 0, 0, 32'h42));
    for (int i = 0; i < 15; i++) exp_q.push_back(beat(8'h21, 0, 0, 32'h0));
    exp_q.push_back(beat(8'h21, 0, 1, 32'h1234));
    exp_q.push_back(beat(8'h21, 0, 1, 32'h0));
    compare_beats();
    respond(0, 32'hFFFF_FFFF, 8'h21, 1'b1, 1'b0);

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end
endmodule
